serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
Parallel-to-serial transmitter, the sending end for parallel register data such as the 4-bit capture registers.
- Accepts one DATA_W-bit word per valid/ready handshake.
- Emits it on a single line as a framed serial stream: start bit 0, data LSB first, stop bit 1.
- Each bit is held for CLKS_PER_BIT clocks. Sits between a register/datapath stage and an off-block serial link.

Parameters:
DATA_W, 4, payload width in bits; legal 1..16
CLKS_PER_BIT, 4, clock cycles per serial bit; legal >=1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset asserted, takes effect without clk)
in_valid  input  1  producer has a word on in_data
in_data  input  DATA_W  word to transmit; sampled only on handshake
in_ready  output  1  block can accept a word this cycle
tx  output  1  serial line; idles high
busy  output  1  frame in progress

Behaviour:
- Reset (rst=0) forces these values immediately: tx=1, busy=0, in_ready=0, state=IDLE, bit timer=0, bit index=0, shift register=0.
- First rising edge after rst returns to 1 sets in_ready=1. No word is accepted on that edge.
- Handshake: a word is accepted on a rising edge where in_valid=1 and in_ready=1.
  - The word is latched into the shift register.
  - From the next cycle: in_ready=0, busy=1, tx=0 (start bit).
  - in_data is don't-care after acceptance.
- in_valid with in_ready=0 is ignored. The producer must hold the word until the handshake.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: tx=1; wait for handshake.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx=shift_reg[0]. After each CLKS_PER_BIT cycles, shift right and increment the bit index. Leave after DATA_W bits.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE with in_ready=1 and busy=0 on the same edge.
- Bit timer counts 0..CLKS_PER_BIT-1 and has width $clog2(CLKS_PER_BIT+1). It wraps at CLKS_PER_BIT-1; the wrap is the bit-end strobe. CLKS_PER_BIT=1 gives a strobe every cycle.
- Frame length without parity is (DATA_W+2)*CLKS_PER_BIT cycles, from the first start-bit cycle to the last stop-bit cycle.
- Back-to-back words: in_ready rises the cycle after the stop bit ends. A word held valid is accepted on that edge, so the minimum gap is 1 idle-high cycle between frames.
- tx and busy are registered outputs (no combinational path from inputs).
- Reset mid-frame: the frame is abandoned and tx returns to 1 asynchronously. The word is not retransmitted.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined: PARITY state is inserted after DATA.
  - tx = even parity (XOR of all DATA_W bits latched at handshake) for CLKS_PER_BIT cycles.
  - Frame length becomes (DATA_W+3)*CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic; DATA goes directly to STOP.

Decomposition:
- Package serial_pkg holds:
  - state encoding: IDLE, START, DATA, PARITY, STOP; 3-bit, PARITY encoded even when unused
  - constant TX_IDLE_LEVEL=1
  - constant TX_START_LEVEL=0
- Natural sub-module: bit_timer.
  - Parameter CLKS_PER_BIT.
  - Ports: clk, rst, clear, tick.
  - Generates the bit-end strobe; cleared on handshake.

Test Plan:
- Reset release: hold rst=0 for 3 cycles, then rst=1 -> tx=1, busy=0 throughout reset; in_ready=1 one edge after release.
- Single frame, DATA_W=4, CLKS_PER_BIT=4, word 4'b1010 -> tx = 0,0,1,0,1,1, each held 4 cycles (24 cycles); busy=1 for exactly 24 cycles; in_ready=1 next cycle.
- Back-to-back: in_valid held high with 4'hF then 4'h0 -> second start bit begins exactly 1 idle-high cycle after the first stop bit ends; in_data changes mid-frame do not alter tx.
- Mid-frame reset: rst=0 during the second data bit -> tx=1 and busy=0 before the next clk edge; after release, no residual bits are sent.
- CLKS_PER_BIT=1, word 4'b0110 -> tx = 0,0,1,1,0,1 on consecutive cycles.
- With SERIAL_TX_PARITY_EN, word 4'b0111 -> parity bit 1 inserted before stop; frame is 28 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - state encoding and line levels shared by serial_tx
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic TX_IDLE_LEVEL  = 1'b1;
    localparam logic TX_START_LEVEL = 1'b0;

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - free-running bit period counter; tick marks the last cycle of a bit
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Clearing on the handshake aligns every frame to a fresh bit period.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - framed LSB-first serial transmitter; SERIAL_TX_PARITY_EN adds an even parity bit
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx,
    output logic              busy
);

    localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              tick;
    logic              accept;

    assign accept   = in_valid && ready_q;
    assign in_ready = ready_q;
    assign tx       = tx_q;
    assign busy     = busy_q;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(accept),
        .tick (tick)
    );

`ifdef SERIAL_TX_PARITY_EN
    localparam tx_state_e AFTER_DATA = PARITY;
    logic parity_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^in_data;
        end
    end
`else
    localparam tx_state_e AFTER_DATA = STOP;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    shift_d = in_data;
                    idx_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = AFTER_DATA;
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        tx_d    = TX_IDLE_LEVEL;
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
        case (state_d)
            START:   tx_d = TX_START_LEVEL;
            DATA:    tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = TX_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= TX_IDLE_LEVEL;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - scoreboard bench for serial_tx at CLKS_PER_BIT 4 and 1
module tb_serial_tx;

    localparam int NW = 20;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FB = 7;
`else
    localparam int FB = 6;
`endif

    logic       clk = 1'b0;
    int         checks = 0;
    int         failures = 0;
    logic [3:0] dir [5] = '{4'b1010, 4'hF, 4'h0, 4'b0110, 4'b0111};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_i
        localparam int CPB = (g == 0) ? 4 : 1;

        logic          rst_l;
        logic          vld;
        logic [3:0]    dat;
        logic          rdy, txo, bsy;
        logic          exp_q[$];
        logic          rdy_m = 1'b0;
        int            acc_cnt = 0;
        logic [FB-1:0] fb;
        logic          et, eb, er;
        bit            done = 1'b0;

        serial_tx #(
            .DATA_W      (4),
            .CLKS_PER_BIT(CPB)
        ) dut (
            .clk     (clk),
            .rst     (rst_l),
            .in_valid(vld),
            .in_data (dat),
            .in_ready(rdy),
            .tx      (txo),
            .busy    (bsy)
        );

        // Reference: an accepted word becomes the list of line levels, one entry per clock.
        always @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                exp_q.delete();
                rdy_m = 1'b0;
            end else begin
                if (vld && rdy_m) begin
`ifdef SERIAL_TX_PARITY_EN
                    fb = {1'b1, ^dat, dat, 1'b0};
`else
                    fb = {1'b1, dat, 1'b0};
`endif
                    for (int i = 0; i < FB; i++)
                        for (int c = 0; c < CPB; c++) exp_q.push_back(fb[i]);
                    acc_cnt++;
                end
                rdy_m = (exp_q.size() == 0);
            end
        end

        always @(negedge clk) begin
            if (!rst_l) begin
                et = 1'b1; eb = 1'b0; er = 1'b0;
            end else if (exp_q.size() != 0) begin
                et = exp_q.pop_front(); eb = 1'b1; er = 1'b0;
            end else begin
                et = 1'b1; eb = 1'b0; er = rdy_m;
            end
            checks++;
            if ({txo, bsy, rdy} !== {et, eb, er}) begin
                failures++;
                $display("FAIL line%0d t=%0t tx/busy/in_ready got %b%b%b want %b%b%b",
                         g, $time, txo, bsy, rdy, et, eb, er);
            end
        end

        initial begin
            int prev;
            int wait_n;
            logic [3:0] w;
            rst_l = 1'b0; vld = 1'b0; dat = '0;
            repeat (3) @(posedge clk);
            #1 rst_l = 1'b1;
            for (int n = 0; n < NW; n++) begin
                w = (n < 5) ? dir[n] : 4'($urandom);
                if (n == 7) w = 4'b0101;
                if (n >= 3 && $urandom_range(0, 1) == 1) begin
                    vld = 1'b0;
                    dat = 4'($urandom);
                    repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                end
                vld = 1'b1;
                dat = w;
                prev = acc_cnt;
                wait_n = 0;
                while (acc_cnt == prev && wait_n < 100) begin
                    @(posedge clk); #1;
                    wait_n++;
                end
                checks++;
                if (acc_cnt == prev) begin
                    failures++;
                    $display("FAIL accept%0d word %0d not taken within %0d cycles", g, n, wait_n);
                end
                if (n == 7) begin
                    vld = 1'b0;
                    repeat (2 * CPB) @(posedge clk);
                    #2 rst_l = 1'b0;
                    #1;
                    checks++;
                    if ({txo, bsy, rdy} !== 3'b100) begin
                        failures++;
                        $display("FAIL async_rst%0d tx/busy/in_ready got %b%b%b want 100",
                                 g, txo, bsy, rdy);
                    end
                    repeat (3) @(posedge clk);
                    #1 rst_l = 1'b1;
                end
            end
            vld = 1'b0;
            wait_n = 0;
            while (exp_q.size() != 0 && wait_n < 200) begin
                @(posedge clk);
                wait_n++;
            end
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL drain%0d %0d expected cycles left, want 0", g, exp_q.size());
            end
            repeat (3) @(posedge clk);
            done = 1'b1;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(g_i[0].done && g_i[1].done) && cyc < 50000) begin
            @(posedge clk);
            cyc++;
        end
        if (!(g_i[0].done && g_i[1].done)) begin
            failures++;
            $display("FAIL finish bench stalled after %0d cycles, want completion", cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
